branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/bp_pkg.sv | 18 +
 rtl/bp_sat_counter.sv | 24 ++
 rtl/branch_predictor.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: counter encodings and default table size.
package bp_pkg;

    // 2-bit saturating counter encodings
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Default number of prediction table entries
    localparam int unsigned BP_ENTRIES = 16;

    // A counter predicts taken in WT or ST, i.e. when its MSB is set
    function automatic logic ctr_taken(input logic [1:0] ctr);
        return ctr[1];
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for a 2-bit saturating branch counter.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] count,
    input  logic       taken,
    output logic [1:0] next
);

    // Step toward ST on taken, toward SNT on not-taken, holding at either end
    always_comb begin
        next = count;
        if (taken) begin
            if (count != CTR_ST) begin
                next = count + 2'd1;
            end
        end else begin
            if (count != CTR_SNT) begin
                next = count - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters, mispredict detection
// and branch/mispredict performance counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES = BP_ENTRIES,
    parameter int unsigned XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_f,
    output logic            predict_taken,
    output logic [XLEN-1:0] predict_target,
    input  logic            update_en,
    input  logic [XLEN-1:0] update_pc,
    input  logic            update_taken,
    input  logic [XLEN-1:0] update_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispred_cnt
);

    localparam int unsigned IDX   = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX - 2;

    // Table state
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [XLEN-1:0]    target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];

    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    logic [IDX-1:0]   pf_idx;
    logic [TAG_W-1:0] pf_tag;
    logic             pf_hit;
    logic [IDX-1:0]   upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic [1:0]       ctr_next;

    // Byte-offset bits never take part in indexing or tagging
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_f[1:0], update_pc[1:0]};

    assign pf_idx  = pc_f[IDX+1:2];
    assign pf_tag  = pc_f[XLEN-1:IDX+2];
    assign upd_idx = update_pc[IDX+1:2];
    assign upd_tag = update_pc[XLEN-1:IDX+2];

    // Counter step for the entry being updated
    bp_sat_counter u_sat_counter (
        .count (ctr_q[upd_idx]),
        .taken (update_taken),
        .next  (ctr_next)
    );

    // Fetch-side lookup: reads registered contents only, so updates land a cycle later
    always_comb begin
        pf_hit         = valid_q[pf_idx] && (tag_q[pf_idx] == pf_tag);
        predict_taken  = rst && pf_hit && ctr_taken(ctr_q[pf_idx]);
        predict_target = predict_taken ? target_q[pf_idx] : pc_f + XLEN'(4);
    end

    // Mispredict detection and the corrected fetch address
    always_comb begin
        flush = update_en &&
                ((ex_pred_taken != update_taken) ||
                 (ex_pred_taken && update_taken && (ex_pred_target != update_target)));
        redirect_pc = update_taken ? update_target : update_pc + XLEN'(4);
    end

    // Table next state: train on hit, allocate only on a taken miss
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        if (update_en) begin
            if (upd_hit) begin
                ctr_d[upd_idx] = ctr_next;
                if (update_taken) begin
                    target_d[upd_idx] = update_target;
                end
            end else if (update_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = update_target;
                ctr_d[upd_idx]    = CTR_WT;
            end
        end
    end

    // Performance counter next state; both wrap naturally at 32 bits
    always_comb begin
        branch_cnt_d  = branch_cnt_q + {31'd0, update_en};
        mispred_cnt_d = mispred_cnt_q + {31'd0, flush};
    end

    // Table state registers with asynchronous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

    // Performance counter registers with asynchronous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule
